// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control sequencer for the single-datapath MIPS core.
// One instruction moves through FETCH, DECODE, EXEC, MEM and WB. The state
// register and the retired counter are the only storage. Every datapath
// control is a decode of the current state plus the IR opcode/funct fields.
// That decode is combinational on purpose: DECODE depends on an opcode that
// is only loaded by the FETCH edge, and the beq PC write follows zero_flag
// during EXEC.
// Memory handshake: in MEM the lw/sw strobe stays high in every cycle until
// mem_ready is sampled high at a rising edge. That edge completes the access.
// mem_ready is ignored in all other states.
module mips_multicycle_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero_flag,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic [1:0]          alu_src_b,
  output logic [3:0]          alu_op,
  output logic [2:0]          state,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t              r_state;
  logic [RETIRE_W-1:0] r_retired;

  logic       w_is_r, w_is_addi, w_is_lui, w_is_lw, w_is_sw, w_is_beq, w_is_j;
  logic       w_r_ok, w_legal;
  logic [3:0] w_alu_op;
  logic [1:0] w_alu_src_b;

  // Instruction class decode and the ALU controls each class needs.
  always_comb begin
    w_is_r      = (opcode == 6'b000000);
    w_is_addi   = (opcode == 6'b001000);
    w_is_lui    = (opcode == 6'b001111);
    w_is_lw     = (opcode == 6'b100011);
    w_is_sw     = (opcode == 6'b101011);
    w_is_beq    = (opcode == 6'b000100);
    w_is_j      = (opcode == 6'b000010);
    w_r_ok      = 1'b1;
    w_alu_op    = 4'b0000;
    w_alu_src_b = 2'b00;
    if (w_is_r) begin
      case (funct)
        6'b100000: w_alu_op = 4'b0010;
        6'b100010: w_alu_op = 4'b0110;
        6'b100100: w_alu_op = 4'b0000;
        6'b100101: w_alu_op = 4'b0001;
        6'b101010: w_alu_op = 4'b0111;
        6'b000000: begin
          w_alu_op    = 4'b1000;
          w_alu_src_b = 2'b11;
        end
        default:   w_r_ok = 1'b0;
      endcase
    end else if (w_is_addi || w_is_lw || w_is_sw) begin
      w_alu_op    = 4'b0010;
      w_alu_src_b = 2'b01;
    end else if (w_is_lui) begin
      w_alu_op    = 4'b1001;
      w_alu_src_b = 2'b10;
    end else if (w_is_beq) begin
      w_alu_op    = 4'b0110;
      w_alu_src_b = 2'b00;
    end
    w_legal = (w_is_r && w_r_ok) || w_is_addi || w_is_lui || w_is_lw ||
              w_is_sw || w_is_beq || w_is_j;
  end

  // Sequencer state and retired-instruction counter. A retire is any move
  // back to FETCH, except the IDLE -> FETCH move out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          if (w_is_j) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + 1'b1;
          end else if (!w_legal) begin
            r_state <= S_TRAP;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_beq) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + 1'b1;
          end else if (w_is_lw || w_is_sw) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (w_is_lw) begin
              r_state <= S_WB;
            end else begin
              r_state   <= S_FETCH;
              r_retired <= r_retired + 1'b1;
            end
          end
        end
        S_WB: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + 1'b1;
        end
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Moore output decode. Every control defaults to 0, so IDLE, TRAP and
  // the unused code only assert what their own branch names.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 4'b0000;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        if (w_is_j) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
      end
      S_EXEC: begin
        alu_op    = w_alu_op;
        alu_src_b = w_alu_src_b;
        if (w_is_beq) begin
          pc_write = zero_flag;
          pc_src   = 2'b01;
        end
      end
      S_MEM: begin
        alu_op    = w_alu_op;
        alu_src_b = w_alu_src_b;
        mem_read  = w_is_lw;
        mem_write = w_is_sw;
      end
      S_WB: begin
        alu_op     = w_alu_op;
        alu_src_b  = w_alu_src_b;
        reg_write  = 1'b1;
        reg_dst    = w_is_r;
        mem_to_reg = w_is_lw;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl with a 4-bit retired counter.
// The driver issues one instruction at a time. For every cycle it pushes
// the hand-computed output vector it expects. A separate monitor pops each
// vector and compares it on the falling edge. It also compares when the
// driver raises a probe strobe during an asynchronous reset.
module tb_mips_multicycle_ctrl;

  localparam int W = 23;
  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero_flag, mem_ready;
  logic       pc_write, ir_write, reg_write, reg_dst;
  logic       mem_read, mem_write, mem_to_reg, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_op;
  logic [2:0] state;
  logic [3:0] retired;

  mips_multicycle_ctrl #(.RETIRE_W(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_src(pc_src), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .illegal(illegal), .retired(retired)
  );

  // Clock and reset block.
  always #5 clock = ~clock;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [3:0]   exp_ret;
  logic         probe = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] w_act;

  assign w_act = {state, pc_write, pc_src, ir_write, reg_write, reg_dst,
                  mem_read, mem_write, mem_to_reg, alu_src_b, alu_op,
                  illegal, retired};

  function automatic logic [W-1:0] mk(
    input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
    input logic irw, input logic rw, input logic rd, input logic mr,
    input logic mw, input logic m2r, input logic [1:0] asb,
    input logic [3:0] aop, input logic ill, input logic [3:0] ret);
    return {st, pcw, pcs, irw, rw, rd, mr, mw, m2r, asb, aop, ill, ret};
  endfunction

  // Scoreboard monitor.
  always @(negedge clock or posedge probe) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      n_vec++;
      if (w_act !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h (state %0d retired %0d)",
                 n, w_act, e, state, retired);
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: wait expired before the test finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Driver tasks.
  task automatic cyc(input string nm, input logic [W-1:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  task automatic rand_in();
    mem_ready = 1'($urandom_range(0, 1));
    zero_flag = 1'($urandom_range(0, 1));
  endtask

  // Holds reset for one cycle, then releases it. Expects IDLE for one cycle
  // after the release. Returns at the start of the first FETCH cycle.
  task automatic reset_release(input string nm);
    reset = 1'b1;
    rand_in();
    cyc({nm, ":in_reset"}, '0);
    reset = 1'b0;
    exp_ret = 4'd0;
    rand_in();
    cyc({nm, ":idle"}, '0);
  endtask

  task automatic run_instr(input string nm, input logic [5:0] op,
                           input logic [5:0] fn, input int kind,
                           input logic [3:0] aop, input logic [1:0] asb,
                           input logic rdst, input logic zf, input int waits);
    logic lw, sw;
    lw = (kind == K_LW);
    sw = (kind == K_SW);
    opcode = op;
    funct  = fn;
    rand_in();
    cyc({nm, ":fetch"}, mk(3'd1, 1, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, exp_ret));
    rand_in();
    if (kind == K_J) begin
      cyc({nm, ":decode"}, mk(3'd2, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, exp_ret));
      exp_ret++;
      return;
    end
    cyc({nm, ":decode"}, mk(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, exp_ret));
    rand_in();
    if (kind == K_BEQ) begin
      zero_flag = zf;
      cyc({nm, ":exec"}, mk(3'd3, zf, 2'b01, 0, 0, 0, 0, 0, 0, asb, aop, 0, exp_ret));
      exp_ret++;
      return;
    end
    cyc({nm, ":exec"}, mk(3'd3, 0, 2'b00, 0, 0, 0, 0, 0, 0, asb, aop, 0, exp_ret));
    if (lw || sw) begin
      for (int k = 0; k <= waits; k++) begin
        rand_in();
        mem_ready = (k == waits);
        cyc({nm, ":mem"}, mk(3'd4, 0, 2'b00, 0, 0, 0, lw, sw, 0, asb, aop, 0, exp_ret));
      end
      if (sw) begin
        exp_ret++;
        return;
      end
    end
    rand_in();
    cyc({nm, ":wb"}, mk(3'd5, 0, 2'b00, 0, 1, rdst, 0, 0, lw, asb, aop, 0, exp_ret));
    exp_ret++;
  endtask

  task automatic run_trap(input string nm, input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    rand_in();
    cyc({nm, ":fetch"}, mk(3'd1, 1, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, exp_ret));
    rand_in();
    cyc({nm, ":decode"}, '0 | mk(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, exp_ret));
    for (int k = 0; k < 4; k++) begin
      rand_in();
      cyc({nm, ":trap"}, mk(3'd6, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 1, exp_ret));
    end
  endtask

  initial begin
    reset = 1'b1;
    opcode = 6'b0;
    funct = 6'b0;
    zero_flag = 1'b0;
    mem_ready = 1'b0;
    exp_ret = 4'd0;
    @(posedge clock);
    #1;
    reset_release("por");

    run_instr("add", 6'b000000, 6'b100000, K_ALU, 4'b0010, 2'b00, 1, 0, 0);

    // Reset in the middle of an add's EXEC cycle.
    opcode = 6'b000000;
    funct  = 6'b100000;
    cyc("rst_add:fetch", mk(3'd1, 1, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, exp_ret));
    cyc("rst_add:decode", mk(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, exp_ret));
    exp_q.push_back(mk(3'd3, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010, 0, exp_ret));
    name_q.push_back("rst_add:exec");
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    if (state !== 3'd0 || w_act !== '0) begin
      n_err++;
      $display("FAIL rst_add:reset_state: state %0d outputs %h, expected all 0",
               state, w_act);
    end
    exp_q.push_back('0);
    name_q.push_back("rst_add:async");
    probe = 1'b1;
    #1;
    probe = 1'b0;
    @(posedge clock);
    #1;
    reset_release("rst_add");

    // Sixteen retirements from reset, so the 4-bit counter wraps to 0.
    run_instr("sub",  6'b000000, 6'b100010, K_ALU, 4'b0110, 2'b00, 1, 0, 0);
    run_instr("and",  6'b000000, 6'b100100, K_ALU, 4'b0000, 2'b00, 1, 0, 0);
    run_instr("or",   6'b000000, 6'b100101, K_ALU, 4'b0001, 2'b00, 1, 0, 0);
    run_instr("slt",  6'b000000, 6'b101010, K_ALU, 4'b0111, 2'b00, 1, 0, 0);
    run_instr("sll",  6'b000000, 6'b000000, K_ALU, 4'b1000, 2'b11, 1, 0, 0);
    run_instr("addi", 6'b001000, 6'b010101, K_ALU, 4'b0010, 2'b01, 0, 0, 0);
    run_instr("lui",  6'b001111, 6'b000000, K_ALU, 4'b1001, 2'b10, 0, 0, 0);
    run_instr("lw_w3", 6'b100011, 6'b000000, K_LW, 4'b0010, 2'b01, 0, 0, 3);
    run_instr("lw_w0", 6'b100011, 6'b111111, K_LW, 4'b0010, 2'b01, 0, 0, 0);
    run_instr("sw_w2", 6'b101011, 6'b000000, K_SW, 4'b0010, 2'b01, 0, 0, 2);
    run_instr("sw_w0", 6'b101011, 6'b000000, K_SW, 4'b0010, 2'b01, 0, 0, 0);
    run_instr("beq_t", 6'b000100, 6'b000000, K_BEQ, 4'b0110, 2'b00, 0, 1, 0);
    run_instr("beq_n", 6'b000100, 6'b000000, K_BEQ, 4'b0110, 2'b00, 0, 0, 0);
    run_instr("j",     6'b000010, 6'b101010, K_J, 4'h0, 2'b00, 0, 0, 0);
    run_instr("add2",  6'b000000, 6'b100000, K_ALU, 4'b0010, 2'b00, 1, 0, 0);
    run_instr("j2",    6'b000010, 6'b000000, K_J, 4'h0, 2'b00, 0, 0, 0);
    // exp_ret is 0 here: the first FETCH below shows the wrapped count.
    run_instr("post_wrap", 6'b000000, 6'b100000, K_ALU, 4'b0010, 2'b00, 1, 0, 0);

    run_trap("ill_op", 6'b111111, 6'b100000);
    reset_release("trap_exit");
    run_trap("ill_funct", 6'b000000, 6'b000001);
    reset_release("final");

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors never compared", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle sequencer for the single-datapath MIPS core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives every datapath control: PC, IR, register-bank and data-memory enables, the mux selects and the ALU opcode. It handshakes with data memory through `mem_ready`, counts retired instructions, and traps on unsupported opcodes. It sits between the instruction register (opcode/funct fields) and the PC, register bank, ALU muxes, ALU and data memory.

## Interface
Parameters:
- `RETIRE_W`, 32, width of the retired-instruction counter.

Ports:
- `clock`  in  1  single clock for the block; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; stable from DECODE until the instruction retires.
- `funct`  in  6  IR[5:0].
- `zero_flag`  in  1  ALU zero, valid in EXEC.
- `mem_ready`  in  1  data memory has completed the current read or write.
- `pc_write`  out  1  PC load enable.
- `pc_src`  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- `ir_write`  out  1  IR load enable.
- `reg_write`  out  1  register-bank write enable.
- `reg_dst`  out  1  write-address select: 0 = rt, 1 = rd.
- `mem_read`  out  1  data-memory read strobe.
- `mem_write`  out  1  data-memory write strobe.
- `mem_to_reg`  out  1  writeback select: 0 = ALU result, 1 = read data.
- `alu_src_b`  out  2  00 = register, 01 = sign-extended immediate, 10 = zero-filled immediate, 11 = shamt.
- `alu_op`  out  4  ALU opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 SLL, 1001 LUI.
- `state`  out  3  current state, for debug.
- `illegal`  out  1  high while in TRAP.
- `retired`  out  RETIRE_W  count of retired instructions.

## Operation
State encoding: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 6. Code 7 is unreachable; if entered, go to IDLE.

Outputs are a Moore decode of `state` plus `opcode`/`funct`. Any output not listed for a state is 0.
- **IDLE:** all outputs 0. Next state is FETCH.
- **FETCH:** `ir_write` = 1, `pc_write` = 1, `pc_src` = 00. Next state is DECODE.
- **DECODE:** selects the path by instruction class.
  - Supported instructions:
    - R-type (opcode 000000): funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll.
    - addi 001000, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
  - Jump: `pc_write` = 1, `pc_src` = 10; next state FETCH (retire).
  - Any other opcode, or an R-type funct not listed: next state TRAP.
  - Otherwise: next state EXEC.
- **EXEC:** drive `alu_op` and `alu_src_b` per class.
  - R-type: `alu_src_b` = 00 (11 for sll).
  - addi, lw, sw: ADD with `alu_src_b` = 01.
  - lui: LUI with `alu_src_b` = 10.
  - beq: SUB with `alu_src_b` = 00. `pc_write` = `zero_flag`, `pc_src` = 01. Next state FETCH (retire).
  - lw, sw: next state MEM. Others: next state WB.
- **MEM:** `alu_op`/`alu_src_b` held at EXEC values. lw drives `mem_read` = 1; sw drives `mem_write` = 1.
  - Strobe is held until `mem_ready` = 1 at a rising edge.
  - On that edge: lw goes to WB; sw goes to FETCH (retire).
  - `mem_ready` is ignored in every other state.
- **WB:** `reg_write` = 1.
  - `reg_dst` = 1 for R-type, 0 otherwise.
  - `mem_to_reg` = 1 for lw only.
  - ALU controls held at EXEC values.
  - Next state FETCH (retire).
- **TRAP:** `illegal` = 1, all enables 0. The block stays here until reset.
- **`retired`:** increments by 1 on every retire transition (DECODE→FETCH for j; EXEC/MEM/WB→FETCH). It wraps from all-ones to 0. It does not count IDLE→FETCH.

## Timing
- **Reset:** asynchronous. Immediately forces `state` = IDLE and `retired` = 0, so every output reads 0. First FETCH occurs on the 2nd rising edge after reset deasserts.
- **Instruction latency, FETCH to next FETCH:**
  - j: 2 cycles.
  - beq: 3 cycles.
  - R-type, addi, lui: 4 cycles.
  - sw: 4 + W cycles.
  - lw: 5 + W cycles.
  - W = number of MEM cycles in which `mem_ready` = 0 (W ≥ 0).
- **Handshake:** `mem_ready` high in the first MEM cycle gives W = 0. The strobe is never deasserted before acceptance. Exactly one strobe is active per MEM visit.
- **Reset mid-operation:** the state is lost and the strobe drops in the same cycle. No write-enable pulse may leak during or after reset.
- `pc_write` and `reg_write` are each high for at most one cycle per state visit.

## Test plan
- **Reset:** assert reset mid-EXEC of an add. → All outputs 0 and `state` = 0 asynchronously. After release: IDLE for 1 cycle, then FETCH.
- **add:** add (000000/100000). → `state` sequence 1,2,3,5,1. In WB, `reg_write` = 1, `reg_dst` = 1, `alu_op` = 0010. `retired` goes 0→1.
- **lw with wait states:** lw, `mem_ready` low for 3 MEM cycles. → `mem_read` high for exactly 4 cycles. WB has `mem_to_reg` = 1, `reg_dst` = 0. Total latency 8 cycles.
- **beq:** beq with `zero_flag` = 1, then with `zero_flag` = 0. → EXEC `pc_write` = 1/`pc_src` = 01 in the first case; `pc_write` = 0 in the second. Each takes 3 cycles.
- **j and lui:** j → DECODE `pc_write` = 1, `pc_src` = 10, 2 cycles. lui → `alu_op` = 1001, `alu_src_b` = 10.
- **Illegal and wrap:** opcode 111111 → TRAP, `illegal` = 1, `retired` frozen until reset. With `RETIRE_W` = 4: 16 retirements → `retired` wraps to 0.
